// File: rtl/mynios2_cpu_oci_mem_arbiter.sv
// ---------------------------------------------------------------------------
// mynios2_cpu_oci_mem_arbiter
//
// Shares the single-port OCI debug RAM (1-cycle read latency) between the
// JTAG debug path (sysclk-domain take_action_ocimem_* strobes + jdo) and the
// CPU's Avalon debug slave port. JTAG reads land in MonDReg; the monitor_*
// flags report JTAG progress and overrun. Avalon is stalled with
// av_waitrequest until its access has been served.
//
// Ports
//   clk, reset_n                     clock, async active-low reset
//   take_action_ocimem_a             load JTAG address (jdo[35]: read, jdo[36]: clear error)
//   take_action_ocimem_b             JTAG write of jdo[34:3] at the JTAG address
//   take_no_action_ocimem_a          JTAG read at the JTAG address
//   jdo[37:0]                        JTAG data, valid with the strobes
//   av_address/read/write/writedata  Avalon slave request
//   av_readdata, av_waitrequest      Avalon slave response
//   mem_addr/wdata/we/re, mem_rdata  OCI RAM port (read data one cycle after mem_re)
//   MonDReg                          last JTAG read data
//   monitor_ready                    no JTAG op pending or in flight
//   monitor_error                    sticky JTAG overrun / strobe conflict
//
// State table
//   state  | meaning
//   IDLE   | no memory access; grant JTAG or Avalon (round-robin on a tie)
//   J_RD   | JTAG read issued (mem_re)
//   J_CAP  | JTAG read data captured into MonDReg, address advances
//   J_WR   | JTAG write issued (mem_we), address advances
//   A_RD   | Avalon read issued (mem_re)
//   A_CAP  | Avalon read data returned, waitrequest released
//   A_WR   | Avalon write issued (mem_we), waitrequest released
// ---------------------------------------------------------------------------
module mynios2_cpu_oci_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [37:0]       jdo,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [DATA_W-1:0] av_writedata,
    output logic [DATA_W-1:0] av_readdata,
    output logic              av_waitrequest,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_J_RD  = 3'd1,
        S_J_CAP = 3'd2,
        S_J_WR  = 3'd3,
        S_A_RD  = 3'd4,
        S_A_CAP = 3'd5,
        S_A_WR  = 3'd6
    } state_t;

    localparam logic GRANT_AV   = 1'b0;
    localparam logic GRANT_JTAG = 1'b1;

    state_t            state;
    state_t            state_nxt;

    logic [ADDR_W-1:0] jtag_addr;
    logic              jtag_pend;
    logic              jtag_is_wr;
    logic [DATA_W-1:0] jtag_wdata;
    logic              last_grant;

    // strobe decode
    logic              req_queue;
    logic              req_wr;
    logic              lower_drop;
    logic              addr_load;
    logic              err_clr;
    logic              jtag_busy;
    logic              q_accept;
    logic              q_drop;

    // arbitration
    logic              av_req;
    logic              grant_jtag;
    logic              grant_av;

    // jdo[37] and jdo[2:0] carry nothing for the memory path
    logic              unused_jdo_bits;
    assign unused_jdo_bits = ^{jdo[37], jdo[2:0]};

    // -----------------------------------------------------------------------
    // JTAG strobe decode: b > a > no_action, one command per cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        req_queue  = 1'b0;
        req_wr     = 1'b0;
        lower_drop = 1'b0;
        addr_load  = 1'b0;
        err_clr    = 1'b0;
        if (take_action_ocimem_b) begin
            req_queue  = 1'b1;
            req_wr     = 1'b1;
            lower_drop = take_action_ocimem_a | take_no_action_ocimem_a;
        end else if (take_action_ocimem_a) begin
            addr_load  = 1'b1;
            req_queue  = jdo[35];
            err_clr    = jdo[36];
            lower_drop = take_no_action_ocimem_a;
        end else if (take_no_action_ocimem_a) begin
            req_queue  = 1'b1;
        end
    end

    // A JTAG op occupies the single queue slot from acceptance until the
    // cycle it finishes (J_CAP or J_WR).
    always_comb begin
        jtag_busy = jtag_pend
                  | (state == S_J_RD)
                  | (state == S_J_CAP)
                  | (state == S_J_WR);
        q_accept  = req_queue & ~jtag_busy;
        q_drop    = req_queue &  jtag_busy;
    end

    // -----------------------------------------------------------------------
    // Grant decision, only meaningful in IDLE. A tie goes to the side that
    // was not granted last.
    // -----------------------------------------------------------------------
    always_comb begin
        av_req     = av_read | av_write;
        grant_jtag = (state == S_IDLE) & jtag_pend
                   & (~av_req | (last_grant == GRANT_AV));
        grant_av   = (state == S_IDLE) & av_req
                   & (~jtag_pend | (last_grant == GRANT_JTAG));
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (grant_jtag) begin
                    state_nxt = jtag_is_wr ? S_J_WR : S_J_RD;
                end else if (grant_av) begin
                    // read and write together is served as a write
                    state_nxt = av_write ? S_A_WR : S_A_RD;
                end
            end
            S_J_RD:  state_nxt = S_J_CAP;
            S_J_CAP: state_nxt = S_IDLE;
            S_J_WR:  state_nxt = S_IDLE;
            S_A_RD:  state_nxt = S_A_CAP;
            S_A_CAP: state_nxt = S_IDLE;
            S_A_WR:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs. Each state drives at most one of mem_re / mem_we.
    // -----------------------------------------------------------------------
    always_comb begin
        mem_addr       = '0;
        mem_wdata      = '0;
        mem_we         = 1'b0;
        mem_re         = 1'b0;
        av_waitrequest = 1'b1;
        av_readdata    = '0;
        case (state)
            S_J_RD: begin
                mem_re   = 1'b1;
                mem_addr = jtag_addr;
            end
            S_J_WR: begin
                mem_we    = 1'b1;
                mem_addr  = jtag_addr;
                mem_wdata = jtag_wdata;
            end
            S_A_RD: begin
                mem_re   = 1'b1;
                mem_addr = av_address;
            end
            S_A_CAP: begin
                av_readdata    = mem_rdata;
                av_waitrequest = 1'b0;
            end
            S_A_WR: begin
                mem_we         = 1'b1;
                mem_addr       = av_address;
                mem_wdata      = av_writedata;
                av_waitrequest = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // JTAG queue, address pointer, monitor registers, round-robin memory
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jtag_addr     <= '0;
            jtag_pend     <= 1'b0;
            jtag_is_wr    <= 1'b0;
            jtag_wdata    <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
            last_grant    <= GRANT_AV;
        end else begin
            if (grant_jtag) begin
                jtag_pend  <= 1'b0;
                last_grant <= GRANT_JTAG;
            end else if (grant_av) begin
                last_grant <= GRANT_AV;
            end

            // q_accept implies the slot is free, so it never races grant_jtag
            if (q_accept) begin
                jtag_pend     <= 1'b1;
                jtag_is_wr    <= req_wr;
                monitor_ready <= 1'b0;
                if (req_wr) begin
                    jtag_wdata <= jdo[34:3];
                end
            end

            if (state == S_J_CAP) begin
                MonDReg <= mem_rdata;
            end

            if ((state == S_J_CAP) || (state == S_J_WR)) begin
                jtag_addr     <= jtag_addr + ADDR_W'(1);
                monitor_ready <= 1'b1;
            end

            // a fresh address load overrides the post-access increment
            if (addr_load) begin
                jtag_addr <= jdo[16+ADDR_W:17];
            end

            // a new overrun in the same cycle as a clear request wins
            if (q_drop || lower_drop) begin
                monitor_error <= 1'b1;
            end else if (err_clr) begin
                monitor_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mynios2_cpu_oci_mem_arbiter.sv
module tb_mynios2_cpu_oci_mem_arbiter;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              take_a;
    logic              take_b;
    logic              take_na;
    logic [37:0]       jdo;
    logic [ADDR_W-1:0] av_address;
    logic              av_read;
    logic              av_write;
    logic [31:0]       av_writedata;
    logic [31:0]       av_readdata;
    logic              av_waitrequest;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [31:0]       mem_rdata = '0;
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              monitor_error;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mynios2_cpu_oci_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .take_action_ocimem_a    (take_a),
        .take_action_ocimem_b    (take_b),
        .take_no_action_ocimem_a (take_na),
        .jdo                     (jdo),
        .av_address              (av_address),
        .av_read                 (av_read),
        .av_write                (av_write),
        .av_writedata            (av_writedata),
        .av_readdata             (av_readdata),
        .av_waitrequest          (av_waitrequest),
        .mem_addr                (mem_addr),
        .mem_wdata               (mem_wdata),
        .mem_we                  (mem_we),
        .mem_re                  (mem_re),
        .mem_rdata               (mem_rdata),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    // OCI RAM model: word i preloads to 0xC0DE0000+i, 1-cycle read latency
    logic [31:0] mem [256];
    logic        mem_loaded = 1'b0;
    logic        both_seen  = 1'b0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 + 32'(i);
            mem_loaded <= 1'b1;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            if (mem_re) mem_rdata <= mem[mem_addr];
        end
    end

    always @(negedge clk) if (mem_we && mem_re) both_seen <= 1'b1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        take_a  = 1'b0;
        take_b  = 1'b0;
        take_na = 1'b0;
        jdo     = '0;
    endtask

    task automatic strobe_a(input logic [7:0] addr, input logic rd, input logic clr);
        jdo        = '0;
        jdo[24:17] = addr;
        jdo[35]    = rd;
        jdo[36]    = clr;
        take_a     = 1'b1;
        tick();
        clear_strobes();
    endtask

    task automatic strobe_b(input logic [31:0] d);
        jdo       = '0;
        jdo[34:3] = d;
        take_b    = 1'b1;
        tick();
        clear_strobes();
    endtask

    task automatic strobe_na();
        take_na = 1'b1;
        tick();
        clear_strobes();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_strobes();
        av_address = '0; av_read = 1'b0; av_write = 1'b0; av_writedata = '0;
        tick(); tick(); tick();
        tests++; if (monitor_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", monitor_ready); end
        tests++; if (monitor_error !== 1'b0) begin fails++; $display("FAIL rst_error: got %b want 0", monitor_error); end
        tests++; if (MonDReg !== 32'h0) begin fails++; $display("FAIL rst_mondreg: got %h want 0", MonDReg); end
        tests++; if (av_waitrequest !== 1'b1) begin fails++; $display("FAIL rst_waitreq: got %b want 1", av_waitrequest); end
        tests++; if ({mem_we, mem_re} !== 2'b00) begin fails++; $display("FAIL rst_mem_en: got %b want 00", {mem_we, mem_re}); end
        tests++; if (av_readdata !== 32'h0) begin fails++; $display("FAIL rst_readdata: got %h want 0", av_readdata); end
        reset_n = 1'b1;
        tick();
        tests++; if ({mem_we, mem_re, monitor_ready} !== 3'b001) begin fails++; $display("FAIL rst_idle: got %b want 001", {mem_we, mem_re, monitor_ready}); end
    endtask

    task automatic test_jtag_rw();
        strobe_a(8'h10, 1'b0, 1'b0);
        tests++; if (monitor_ready !== 1'b1) begin fails++; $display("FAIL jrw_load_ready: got %b want 1", monitor_ready); end
        strobe_b(32'hDEADBEEF);
        tests++; if (monitor_ready !== 1'b0) begin fails++; $display("FAIL jrw_ready_low: got %b want 0", monitor_ready); end
        tick();
        tests++; if ({mem_we, mem_re} !== 2'b10) begin fails++; $display("FAIL jrw_we: got %b want 10", {mem_we, mem_re}); end
        tests++; if (mem_addr !== 8'h10) begin fails++; $display("FAIL jrw_waddr: got %h want 10", mem_addr); end
        tests++; if (mem_wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL jrw_wdata: got %h want deadbeef", mem_wdata); end
        tick();
        tests++; if (monitor_ready !== 1'b1) begin fails++; $display("FAIL jrw_ready_done: got %b want 1", monitor_ready); end
        tests++; if (mem[8'h10] !== 32'hDEADBEEF) begin fails++; $display("FAIL jrw_mem10: got %h want deadbeef", mem[8'h10]); end
        // address advanced past the write
        strobe_na();
        tick();
        tests++; if ({mem_re, mem_addr} !== {1'b1, 8'h11}) begin fails++; $display("FAIL jrw_rd_addr11: got %b/%h want 1/11", mem_re, mem_addr); end
        tick(); tick();
        tests++; if (MonDReg !== 32'hC0DE0011) begin fails++; $display("FAIL jrw_mondreg11: got %h want c0de0011", MonDReg); end
        strobe_a(8'h10, 1'b0, 1'b0);
        strobe_na();
        tick(); tick(); tick();
        tests++; if (MonDReg !== 32'hDEADBEEF) begin fails++; $display("FAIL jrw_mondreg10: got %h want deadbeef", MonDReg); end
        tests++; if (monitor_ready !== 1'b1) begin fails++; $display("FAIL jrw_ready_rd: got %b want 1", monitor_ready); end
    endtask

    task automatic test_avalon();
        av_address = 8'h20; av_writedata = 32'h12345678; av_write = 1'b1;
        #1;
        tests++; if (av_waitrequest !== 1'b1) begin fails++; $display("FAIL av_wr_c1: got %b want 1", av_waitrequest); end
        tick();
        tests++; if ({av_waitrequest, mem_we, mem_addr, mem_wdata} !== {1'b0, 1'b1, 8'h20, 32'h12345678}) begin
            fails++; $display("FAIL av_wr_c2: got wr=%b we=%b a=%h d=%h want 0 1 20 12345678", av_waitrequest, mem_we, mem_addr, mem_wdata); end
        tick();
        av_write = 1'b0;
        av_read  = 1'b1;
        #1;
        tests++; if (av_waitrequest !== 1'b1) begin fails++; $display("FAIL av_rd_c1: got %b want 1", av_waitrequest); end
        tick();
        tests++; if ({av_waitrequest, mem_re, mem_addr} !== {1'b1, 1'b1, 8'h20}) begin fails++; $display("FAIL av_rd_c2: got %b %b %h want 1 1 20", av_waitrequest, mem_re, mem_addr); end
        tick();
        tests++; if (av_waitrequest !== 1'b0) begin fails++; $display("FAIL av_rd_c3_wait: got %b want 0", av_waitrequest); end
        tests++; if (av_readdata !== 32'h12345678) begin fails++; $display("FAIL av_rd_data: got %h want 12345678", av_readdata); end
        tick();
        av_read = 1'b0;
        tests++; if (av_readdata !== 32'h0) begin fails++; $display("FAIL av_rd_idle_data: got %h want 0", av_readdata); end
    endtask

    task automatic test_arbitration();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        // tie after reset: JTAG first
        strobe_na();
        av_address = 8'h20; av_read = 1'b1;
        tick();
        tests++; if ({mem_re, mem_addr, av_waitrequest} !== {1'b1, 8'h00, 1'b1}) begin fails++; $display("FAIL arb1_jrd: got %b %h %b want 1 00 1", mem_re, mem_addr, av_waitrequest); end
        tick();
        tests++; if (av_waitrequest !== 1'b1) begin fails++; $display("FAIL arb1_jcap_wait: got %b want 1", av_waitrequest); end
        tick();
        tests++; if (MonDReg !== 32'hC0DE0000) begin fails++; $display("FAIL arb1_mondreg: got %h want c0de0000", MonDReg); end
        tests++; if (av_waitrequest !== 1'b1) begin fails++; $display("FAIL arb1_idle_wait: got %b want 1", av_waitrequest); end
        tick();
        tests++; if ({mem_re, mem_addr} !== {1'b1, 8'h20}) begin fails++; $display("FAIL arb1_ard: got %b %h want 1 20", mem_re, mem_addr); end
        tick();
        tests++; if ({av_waitrequest, av_readdata} !== {1'b0, 32'h12345678}) begin fails++; $display("FAIL arb1_acap: got %b %h want 0 12345678", av_waitrequest, av_readdata); end
        tick();
        av_read = 1'b0;
        // JTAG-only read via ocimem_a with jdo[35]
        strobe_a(8'h01, 1'b1, 1'b0);
        tick(); tick(); tick();
        tests++; if (MonDReg !== 32'hC0DE0001) begin fails++; $display("FAIL arb_a_read: got %h want c0de0001", MonDReg); end
        // tie again: last grant was JTAG, Avalon first
        strobe_na();
        av_read = 1'b1;
        tick();
        tests++; if ({mem_re, mem_addr, av_waitrequest, monitor_ready} !== {1'b1, 8'h20, 1'b1, 1'b0}) begin
            fails++; $display("FAIL arb2_ard: got %b %h %b %b want 1 20 1 0", mem_re, mem_addr, av_waitrequest, monitor_ready); end
        tick();
        tests++; if ({av_waitrequest, av_readdata} !== {1'b0, 32'h12345678}) begin fails++; $display("FAIL arb2_acap: got %b %h want 0 12345678", av_waitrequest, av_readdata); end
        tick();
        av_read = 1'b0;
        tick();
        tests++; if ({mem_re, mem_addr} !== {1'b1, 8'h02}) begin fails++; $display("FAIL arb2_jrd: got %b %h want 1 02", mem_re, mem_addr); end
        tick(); tick();
        tests++; if ({MonDReg, monitor_ready} !== {32'hC0DE0002, 1'b1}) begin fails++; $display("FAIL arb2_mondreg: got %h %b want c0de0002 1", MonDReg, monitor_ready); end
    endtask

    task automatic test_overrun();
        jdo = '0; jdo[34:3] = 32'h11111111; take_b = 1'b1;
        tick();
        jdo[34:3] = 32'h22222222;
        tick();
        clear_strobes();
        tests++; if (monitor_error !== 1'b1) begin fails++; $display("FAIL ovr_error: got %b want 1", monitor_error); end
        tests++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h03, 32'h11111111}) begin fails++; $display("FAIL ovr_first_wr: got %b %h %h want 1 03 11111111", mem_we, mem_addr, mem_wdata); end
        tick(); tick(); tick();
        tests++; if ({mem_we, monitor_ready} !== 2'b01) begin fails++; $display("FAIL ovr_no_second: got %b want 01", {mem_we, monitor_ready}); end
        tests++; if (mem[3] !== 32'h11111111) begin fails++; $display("FAIL ovr_mem3: got %h want 11111111", mem[3]); end
        strobe_a(8'hFF, 1'b0, 1'b1);
        tests++; if (monitor_error !== 1'b0) begin fails++; $display("FAIL ovr_clear: got %b want 0", monitor_error); end
        // a and no_action together: no_action dropped
        jdo = '0; jdo[24:17] = 8'hFF; take_a = 1'b1; take_na = 1'b1;
        tick();
        clear_strobes();
        tests++; if ({monitor_error, monitor_ready} !== 2'b11) begin fails++; $display("FAIL prio_drop: got %b want 11", {monitor_error, monitor_ready}); end
        tick();
        tests++; if (mem_re !== 1'b0) begin fails++; $display("FAIL prio_no_read: got %b want 0", mem_re); end
        strobe_a(8'hFF, 1'b0, 1'b1);
        tests++; if (monitor_error !== 1'b0) begin fails++; $display("FAIL prio_clear: got %b want 0", monitor_error); end
    endtask

    task automatic test_wrap();
        strobe_b(32'hCAFEF00D);
        tick();
        tests++; if ({mem_we, mem_addr} !== {1'b1, 8'hFF}) begin fails++; $display("FAIL wrap_wr: got %b %h want 1 ff", mem_we, mem_addr); end
        tick();
        tests++; if (mem[255] !== 32'hCAFEF00D) begin fails++; $display("FAIL wrap_memff: got %h want cafef00d", mem[255]); end
        strobe_na();
        tick();
        tests++; if ({mem_re, mem_addr} !== {1'b1, 8'h00}) begin fails++; $display("FAIL wrap_addr0: got %b %h want 1 00", mem_re, mem_addr); end
        tick(); tick();
        tests++; if ({MonDReg, monitor_error} !== {32'hC0DE0000, 1'b0}) begin fails++; $display("FAIL wrap_read: got %h %b want c0de0000 0", MonDReg, monitor_error); end
    endtask

    task automatic test_reset_mid();
        strobe_b(32'h55AA55AA);
        tick();
        tests++; if ({mem_we, mem_addr} !== {1'b1, 8'h01}) begin fails++; $display("FAIL rmid_jwr: got %b %h want 1 01", mem_we, mem_addr); end
        #2;
        reset_n = 1'b0;
        #1;
        tests++; if ({mem_we, monitor_ready, av_waitrequest} !== 3'b011) begin fails++; $display("FAIL rmid_async: got %b want 011", {mem_we, monitor_ready, av_waitrequest}); end
        tick(); tick();
        tests++; if (mem[1] !== 32'hC0DE0001) begin fails++; $display("FAIL rmid_mem1: got %h want c0de0001", mem[1]); end
        tests++; if (MonDReg !== 32'h0) begin fails++; $display("FAIL rmid_mondreg: got %h want 0", MonDReg); end
        reset_n = 1'b1;
        tick(); tick(); tick();
        tests++; if ({mem_we, mem_re, monitor_ready} !== 3'b001) begin fails++; $display("FAIL rmid_discard: got %b want 001", {mem_we, mem_re, monitor_ready}); end
        tests++; if (mem[1] !== 32'hC0DE0001) begin fails++; $display("FAIL rmid_mem1_after: got %h want c0de0001", mem[1]); end
    endtask

    task automatic test_exclusive();
        tests++; if (both_seen !== 1'b0) begin fails++; $display("FAIL mem_we_re_overlap: got %b want 0", both_seen); end
    endtask

    initial begin
        test_reset();
        test_jtag_rw();
        test_avalon();
        test_arbitration();
        test_overrun();
        test_wrap();
        test_reset_mid();
        test_exclusive();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
